// File: rtl/spi_pkg.sv
// Shared definitions for the single-clock SPI link (master and slave ends).
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEL      = 3'd1,
    S_CMD      = 3'd2,
    S_SHIFT    = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_SHIFT = 3'd5,
    S_GAP      = 3'd6
  } mst_state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

  function automatic logic is_rd_data(input logic [1:0] op);
    return op == OP_RD_DATA;
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Width-parameterised shift register: parallel load, MSB-first shift with serial input.
// q_nxt exposes the value the register takes on the next edge.
module spi_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] q,
  output logic [W-1:0] q_nxt
);

  always_comb begin
    q_nxt = q;
    if (load)
      q_nxt = load_val;
    else if (shift_en)
      q_nxt = {q[W-2:0], shift_in};
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      q <= '0;
    else
      q <= q_nxt;
  end

endmodule

// File: rtl/spi_master.sv
// SPI master on the shared system clock: SEL, command bit, 10-bit command, optional 8-bit read.
// Optional SPI_MASTER_REQ_ERR_EN adds req_err, a pulse for each start dropped while busy.
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int IDLE_GAP   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CMD_W-1:0]  cmd_din,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
`ifdef SPI_MASTER_REQ_ERR_EN
  output logic              req_err,
`endif
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  // Terminal counts of the shared bit counter; WAIT_LAST is unused when RD_LATENCY is 1.
  localparam logic [3:0] SHIFT_LAST = 4'(CMD_W - 1);
  localparam logic [3:0] RX_LAST    = 4'(DATA_W - 1);
  localparam logic [3:0] WAIT_LAST  = 4'(RD_LATENCY - 2);
  localparam logic [3:0] GAP_LAST   = 4'(IDLE_GAP - 1);

  mst_state_e state, nxt_state;
  logic [3:0] cnt;
  logic       rd_frame;
  logic       accept;
  cmd_t       cmd_in;

  logic [CMD_W-1:0]  tx_q, tx_nxt;
  logic [DATA_W-1:0] rx_q, rx_nxt;

  logic ss_n_d, mosi_d, done_d, rd_valid_d, rd_cap;

  assign cmd_in = cmd_din;
  assign busy   = (state != S_IDLE);
  assign accept = (nxt_state == S_SEL);

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      state <= S_IDLE;
    else
      state <= nxt_state;
  end

  // Next-state logic; the last GAP cycle doubles as an accept slot for back-to-back frames.
  always_comb begin
    nxt_state = state;
    case (state)
      S_IDLE:     if (start) nxt_state = S_SEL;
      S_SEL:      nxt_state = S_CMD;
      S_CMD:      nxt_state = S_SHIFT;
      S_SHIFT:
        if (cnt == SHIFT_LAST) begin
          if (!rd_frame)            nxt_state = S_GAP;
          else if (RD_LATENCY == 1) nxt_state = S_RD_SHIFT;
          else                      nxt_state = S_RD_WAIT;
        end
      S_RD_WAIT:  if (cnt == WAIT_LAST) nxt_state = S_RD_SHIFT;
      S_RD_SHIFT: if (cnt == RX_LAST)   nxt_state = S_GAP;
      S_GAP:      if (cnt == GAP_LAST)  nxt_state = start ? S_SEL : S_IDLE;
      default:    nxt_state = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered pins
  always_comb begin
    ss_n_d     = 1'b1;
    mosi_d     = 1'b0;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_cap     = 1'b0;
    case (nxt_state)
      S_SEL, S_RD_WAIT, S_RD_SHIFT: ss_n_d = 1'b0;
      S_CMD, S_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = tx_q[CMD_W-1];
      end
      default: ;
    endcase
    if (nxt_state == S_GAP && state != S_GAP) begin
      done_d     = 1'b1;
      rd_valid_d = (state == S_RD_SHIFT);
      rd_cap     = (state == S_RD_SHIFT);
    end
  end

  // Counter restarts on every state change, so it never runs past a terminal count.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      cnt <= '0;
    else if (nxt_state != state || state == S_IDLE)
      cnt <= '0;
    else
      cnt <= cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      rd_frame <= 1'b0;
    else if (accept)
      rd_frame <= is_rd_data(cmd_in.op);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      SS_n     <= 1'b1;
      MOSI     <= 1'b0;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      SS_n     <= ss_n_d;
      MOSI     <= mosi_d;
      done     <= done_d;
      rd_valid <= rd_valid_d;
      if (rd_cap)
        rd_data <= rx_nxt;
    end
  end

`ifdef SPI_MASTER_REQ_ERR_EN
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)
      req_err <= 1'b0;
    else
      req_err <= start && busy && !accept;
  end
`endif

  // TX holds the command; MOSI takes its MSB, shifting from the CMD cycle onward.
  spi_shift_reg #(.W(CMD_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (cmd_din),
    .shift_en (state == S_CMD || state == S_SHIFT),
    .shift_in (1'b0),
    .q        (tx_q),
    .q_nxt    (tx_nxt)
  );

  spi_shift_reg #(.W(DATA_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val ('0),
    .shift_en (state == S_RD_SHIFT),
    .shift_in (MISO),
    .q        (rx_q),
    .q_nxt    (rx_nxt)
  );

  logic unused_bits;
  assign unused_bits = ^{tx_q[CMD_W-2:0], tx_nxt, rx_q, cmd_in.payload};

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: one default DUT plus RD_LATENCY/IDLE_GAP sweep instances.
module tb_spi_master;
  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_din;
  logic [7:0] slave_byte;

  logic [N-1:0] busy, done, rd_valid, ss_n, mosi;
  logic [7:0]   rd_data [N];
`ifdef SPI_MASTER_REQ_ERR_EN
  logic [N-1:0] req_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;
    localparam int GAP = (g == 0) ? 1 : 3;
    logic miso_g;
    int   low_cyc;

    spi_master #(.RD_LATENCY(LAT), .IDLE_GAP(GAP)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .cmd_din  (cmd_din),
      .busy     (busy[g]),
      .done     (done[g]),
      .rd_data  (rd_data[g]),
      .rd_valid (rd_valid[g]),
`ifdef SPI_MASTER_REQ_ERR_EN
      .req_err  (req_err[g]),
`endif
      .SS_n     (ss_n[g]),
      .MOSI     (mosi[g]),
      .MISO     (miso_g)
    );

    // Slave: counts SS_n-low cycles and presents slave_byte MSB-first so that bit i
    // is sampled LAT cycles after the last command bit plus i; idles MISO high.
    always @(negedge clk) begin
      if (ss_n[g] !== 1'b0) begin
        low_cyc = 0;
        miso_g  = 1'b1;
      end else begin
        low_cyc = low_cyc + 1;
        if (low_cyc >= 12 + LAT && low_cyc <= 19 + LAT)
          miso_g = slave_byte[19 + LAT - low_cyc];
        else
          miso_g = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents a command for one edge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [9:0] c);
    cmd_din = c;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  logic [11:0] seq;
  int exp_low [N];
  int exp_gap [N];
  int low_n   [N];
  int gap_n   [N];
  int done_at [N];
  int rdv_at  [N];
  logic [7:0] cap [N];

  initial begin
    rst_n = 1'b1; start = 1'b0; cmd_din = '0; slave_byte = 8'hC3;
    exp_low = '{21, 20, 23};
    exp_gap = '{1, 3, 3};
    repeat (3) @(negedge clk);
    chk("rst_ss_n", ss_n[0], 1);
    chk("rst_mosi", mosi[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_rd_valid", rd_valid[0], 0);
    chk("rst_rd_data", rd_data[0], 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ss_n", ss_n[0], 1);

    // WR_ADDR: SEL then command bit then 10 bits
    launch(10'b00_1010_0101);
    cmd_din = 10'b11_1111_1111;
    seq = 12'b0000_1010_0101;
    for (int j = 0; j < 12; j++) begin
      chk("wr_ss_low", ss_n[0], 0);
      chk("wr_mosi", mosi[0], seq[11-j]);
      chk("wr_done_early", done[0], 0);
      @(negedge clk);
    end
    chk("wr_ss_rise", ss_n[0], 1);
    chk("wr_done", done[0], 1);
    chk("wr_rd_valid", rd_valid[0], 0);
    chk("wr_busy_gap", busy[0], 1);
    @(negedge clk);
    chk("wr_done_pulse", done[0], 0);
    chk("wr_busy_fall", busy[0], 0);

    // RD_DATA with reply 8'hC3
    @(negedge clk);
    launch(10'b11_0000_0011);
    seq = 12'b0111_0000_0011;
    for (int j = 0; j < 21; j++) begin
      chk("rd_ss_low", ss_n[0], 0);
      if (j < 12) chk("rd_mosi", mosi[0], seq[11-j]);
      else        chk("rd_mosi_idle", mosi[0], 0);
      chk("rd_valid_early", rd_valid[0], 0);
      @(negedge clk);
    end
    chk("rd_ss_rise", ss_n[0], 1);
    chk("rd_done", done[0], 1);
    chk("rd_valid", rd_valid[0], 1);
    chk("rd_data", rd_data[0], 8'hC3);
    @(negedge clk);
    chk("rd_valid_pulse", rd_valid[0], 0);
    chk("rd_done_pulse", done[0], 0);
    chk("rd_data_hold", rd_data[0], 8'hC3);

    // Back-to-back with start held high
    @(negedge clk);
    cmd_din = 10'b01_1111_0000;
    start   = 1'b1;
    @(negedge clk);
    cmd_din = 10'b00_0101_0101;
    seq = 12'b0001_1111_0000;
    for (int j = 0; j < 12; j++) begin
      chk("b2b_a_ss_low", ss_n[0], 0);
      chk("b2b_a_mosi", mosi[0], seq[11-j]);
      @(negedge clk);
    end
    chk("b2b_gap_ss", ss_n[0], 1);
    chk("b2b_a_done", done[0], 1);
    @(negedge clk);
    chk("b2b_b_sel", ss_n[0], 0);
    chk("b2b_b_busy", busy[0], 1);
    start   = 1'b0;
    cmd_din = 10'b10_1111_1111;
    seq = 12'b0000_0101_0101;
    for (int j = 0; j < 12; j++) begin
      chk("b2b_b_ss_low", ss_n[0], 0);
      chk("b2b_b_mosi", mosi[0], seq[11-j]);
      @(negedge clk);
    end
    chk("b2b_b_done", done[0], 1);
    @(negedge clk);
    chk("b2b_idle", busy[0], 0);

    // Start while busy during SHIFT is dropped
    @(negedge clk);
    launch(10'b00_1100_0011);
    seq = 12'b0000_1100_0011;
    for (int j = 0; j < 12; j++) begin
      chk("bsy_ss_low", ss_n[0], 0);
      chk("bsy_mosi", mosi[0], seq[11-j]);
`ifdef SPI_MASTER_REQ_ERR_EN
      if (j == 6) chk("req_err_pulse", req_err[0], 1);
      if (j == 7) chk("req_err_clear", req_err[0], 0);
`endif
      if (j == 5) begin
        start   = 1'b1;
        cmd_din = 10'b11_1111_1111;
      end else if (j == 6) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    chk("bsy_done", done[0], 1);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("bsy_no_frame", ss_n[0], 1);
      chk("bsy_idle", busy[0], 0);
    end

    // Reset in the middle of RD_SHIFT
    @(negedge clk);
    launch(10'b11_0000_0001);
    repeat (15) @(negedge clk);
    chk("mid_ss_low", ss_n[0], 0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_ss", ss_n[0], 1);
    chk("mid_rst_mosi", mosi[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_rd_data", rd_data[0], 0);
    chk("mid_rst_rd_valid", rd_valid[0], 0);
    @(negedge clk);
    rst_n = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("post_rst_ss", ss_n[0], 1);
      chk("post_rst_rd_valid", rd_valid[0], 0);
    end
    launch(10'b01_0011_1100);
    seq = 12'b0001_0011_1100;
    for (int j = 0; j < 12; j++) begin
      chk("post_wr_ss_low", ss_n[0], 0);
      chk("post_wr_mosi", mosi[0], seq[11-j]);
      @(negedge clk);
    end
    chk("post_wr_done", done[0], 1);
    chk("post_wr_rd_data", rd_data[0], 0);

    // Sweep: RD_LATENCY 2/1/4, IDLE_GAP 1/3/3 on one shared RD_DATA request
    repeat (6) @(negedge clk);
    slave_byte = 8'h96;
    for (int g = 0; g < N; g++) begin
      low_n[g] = 0; gap_n[g] = 0; done_at[g] = -1; rdv_at[g] = -1; cap[g] = '0;
    end
    launch(10'b11_0101_1010);
    for (int j = 0; j < 40; j++) begin
      for (int g = 0; g < N; g++) begin
        if (ss_n[g] === 1'b0) low_n[g]++;
        if (ss_n[g] === 1'b1 && busy[g] === 1'b1) gap_n[g]++;
        if (done[g] === 1'b1) done_at[g] = j;
        if (rd_valid[g] === 1'b1) begin
          rdv_at[g] = j;
          cap[g]    = rd_data[g];
        end
      end
      @(negedge clk);
    end
    for (int g = 0; g < N; g++) begin
      chk($sformatf("sw%0d_ss_low_len", g), low_n[g], exp_low[g]);
      chk($sformatf("sw%0d_done_at", g), done_at[g], exp_low[g]);
      chk($sformatf("sw%0d_rd_valid_at", g), rdv_at[g], exp_low[g]);
      chk($sformatf("sw%0d_rd_data", g), cap[g], 8'h96);
      chk($sformatf("sw%0d_gap_len", g), gap_n[g], exp_gap[g]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- SPI master: the initiating end of the team's single-clock SPI link. Drives SS_n and MOSI, and samples MISO, all on the shared system clock `clk`. There is no separate SCK.
- Accepts one 10-bit command word per request from a local controller.
- Serialises the command as: select cycle, command bit, then 10 bits MSB-first.
- For read-data commands (opcode 2'b11), holds the slave selected and captures the 8-bit reply from MISO MSB-first.

Parameters:
- RD_LATENCY, 2: cycles between the last transmitted command bit and the first MISO data bit; legal 1..15.
- IDLE_GAP, 1: minimum cycles SS_n stays high between frames; legal 1..15.

Ports:
- clk  input  1  system clock, shared with the slave.
- rst_n  input  1  asynchronous, active-high reset. The name follows codebase convention; polarity is active-high.
- start  input  1  request strobe; accepted only when busy=0.
- cmd_din  input  10  command word. [9:8] = opcode (00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA); [7:0] = address or data.
- busy  output  1  high from the cycle after acceptance until the IDLE_GAP expires.
- done  output  1  one-cycle pulse at frame end, for every opcode.
- rd_data  output  8  captured read byte; holds its value until the next RD_DATA frame completes.
- rd_valid  output  1  one-cycle pulse coincident with done, for RD_DATA frames only.
- SS_n  output  1  slave select, active low, registered.
- MOSI  output  1  serial data to the slave, registered.
- MISO  input  1  serial data from the slave.

Behaviour:
- Reset (asynchronous, immediate, including mid-frame):
  - SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0.
  - FSM goes to IDLE and all counters clear.
  - After reset release, a new frame begins only on a fresh start.
- FSM states: IDLE, SEL, CMD, SHIFT, RD_WAIT, RD_SHIFT, GAP.
- Timing is relative to edge E0, the edge that samples start=1 in IDLE.
  - IDLE: SS_n=1, MOSI=0. start=1 latches cmd_din into the shift register and goes to SEL. start while busy=1 is ignored.
  - After E0 (SEL, 1 cycle): SS_n=0, MOSI=0, busy=1.
  - After E1 (CMD, 1 cycle): MOSI=cmd[9]. This is the read/write command bit the slave decodes.
  - After E2..E11 (SHIFT, 10 cycles): MOSI=cmd[9],cmd[8],...,cmd[0].
  - After E12, opcode != 11: SS_n=1, MOSI=0, done=1, go to GAP.
  - After E12, opcode == 11: go to RD_WAIT. SS_n stays 0, MOSI=0, for RD_LATENCY-1 cycles.
  - RD_SHIFT: sample MISO on 8 consecutive edges, MSB first, into rx_shift[7:0].
  - After the 8th sample: SS_n=1, rd_data=rx_shift, rd_valid=1, done=1, go to GAP.
- GAP:
  - SS_n held high for IDLE_GAP cycles, counting the cycle SS_n rises. busy stays 1.
  - Then IDLE, with busy=0.
  - A start arriving on the same edge busy falls is accepted.
- Frame lengths (SS_n low):
  - Write and read-address frames: 12 cycles.
  - RD_DATA frame: 12 + (RD_LATENCY-1) + 8 cycles.
- Counters: a single 4-bit bit counter, reused per state; it never wraps past its terminal count.
- cmd_din changes after E0 have no effect on the frame in progress.
- MISO is ignored outside RD_SHIFT.

Optional Feature:
- Macro: SPI_MASTER_REQ_ERR_EN.
- When defined:
  - Adds output req_err (1 bit, reset 0).
  - req_err pulses for one cycle whenever start=1 is sampled while busy=1.
  - The dropped request has no other effect.
- When undefined: the port is absent and start while busy is silently ignored.

Decomposition:
- Package spi_pkg holds:
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - CMD_W=10 and DATA_W=8;
  - the master state encoding.
- The package is shared with the slave.
- One natural sub-module, spi_shift_reg: parameterised width, parallel load, MSB-first shift-out and shift-in. The master instantiates it twice (TX 10-bit, RX 8-bit).

Test Plan:
- WR_ADDR: start with cmd_din=10'b00_1010_0101 -> SS_n low 12 cycles; MOSI sequence 0,0,0,0,1,0,1,0,0,1,0,1 after the SEL cycle; done=1 as SS_n rises; rd_valid=0.
- RD_DATA: cmd_din=10'b11_0000_0011, model drives MISO=8'hC3 MSB-first starting RD_LATENCY(2) cycles after the last bit -> rd_data=8'hC3, rd_valid=done=1 for one cycle, SS_n low 21 cycles.
- Back-to-back: start held high continuously, IDLE_GAP=1 -> exactly one SS_n high cycle between frames; the second frame's cmd_din value is latched at acceptance.
- Start while busy (e.g. during SHIFT): current frame unaffected; with SPI_MASTER_REQ_ERR_EN, req_err=1 for one cycle.
- Reset asserted mid-RD_SHIFT -> SS_n=1 immediately, no rd_valid; rd_data=0. After release, a new WR_DATA frame completes normally.
- Parameter sweep RD_LATENCY=1 and 4, IDLE_GAP=3 -> capture alignment and gap length match the stated cycle counts.
